muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the single-cycle CPU's execute stage. Sequences an iterative shift-add multiplier and restoring divider for the MIPS `mult`, `multu`, `div` and `divu` instructions. Owns the HI/LO registers and services `mfhi`, `mflo`, `mthi` and `mtlo`. Drives `stall` so the instruction fetch unit holds the PC while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared funct codes, FSM encoding and iteration-counter width for the mult/div controller.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // Iteration counter wide enough for WIDTH up to 64.
  localparam int ITER_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or, with MULDIV_DIV_EN, the restoring divider.
// Purely combinational; the caller registers acc/rem each CALC cycle.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic                 is_div,
  input  logic [WIDTH:0]       rem,
  output logic [WIDTH:0]       rem_next,
`endif
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
`endif

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, LSB selects the add.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted  = {rem, acc[WIDTH-1]};
    trial    = shifted - {2'b00, opnd};
    rem_next = rem;
    if (is_div) begin
      if (trial[WIDTH+1]) begin
        rem_next = shifted[WIDTH:0];
        acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
      end else begin
        rem_next = trial[WIDTH:0];
        acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative mult/div sequencer owning HI/LO; the divider exists only when MULDIV_DIV_EN is defined.
// HI/LO written WIDTH+1 edges after accept (1 edge for divide by zero); stall = start & busy.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] Read_A,
  input  logic [WIDTH-1:0] Read_B,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] mf_data,
  output logic             illegal
);

  state_t             state, state_nxt;
  logic [ITER_W-1:0]  cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   opnd, mag_a, mag_b, hi_fix, lo_fix;
  logic               neg_q;
  logic               idle, is_mul, is_dv, is_mv_hi, is_mv_lo, is_mf, sgn;
  logic               b_zero, accept, last;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     rem, rem_step;
  logic               is_div_q, dz_q, neg_r;
`endif

  always_comb begin
    idle     = (state == IDLE);
    is_mul   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
`ifdef MULDIV_DIV_EN
    is_dv    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
`else
    is_dv    = 1'b0;
`endif
    is_mv_hi = (funct == FUNCT_MTHI);
    is_mv_lo = (funct == FUNCT_MTLO);
    is_mf    = (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
    sgn      = ~funct[0];
    mag_a    = (sgn && Read_A[WIDTH-1]) ? -Read_A : Read_A;
    mag_b    = (sgn && Read_B[WIDTH-1]) ? -Read_B : Read_B;
    b_zero   = (Read_B == '0);
    accept   = start && idle && (is_mul || is_dv);
    last     = (cnt == ITER_W'(WIDTH - 1));
    mf_data  = (funct == FUNCT_MFHI) ? HI : LO;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    stall     = start && (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = (is_dv && b_zero) ? FIX : CALC;
      CALC:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div   (is_div_q),
    .rem      (rem),
    .rem_next (rem_step),
`endif
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    // Divide by zero parks the raw dividend in acc so it can be returned in HI.
    if (dz_q) begin
      lo_fix = '1;
      hi_fix = acc[WIDTH-1:0];
    end else if (is_div_q) begin
      lo_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      hi_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HI       <= '0;
      LO       <= '0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem      <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done    <= (state == FIX);
      illegal <= start && idle && !(is_mul || is_dv || is_mv_hi || is_mv_lo || is_mf);
      if (accept) begin
        cnt   <= '0;
        neg_q <= sgn && (Read_A[WIDTH-1] ^ Read_B[WIDTH-1]);
        if (is_dv) begin
          opnd <= mag_b;
          acc  <= {{WIDTH{1'b0}}, b_zero ? Read_A : mag_a};
        end else begin
          opnd <= mag_a;
          acc  <= {{WIDTH{1'b0}}, mag_b};
        end
`ifdef MULDIV_DIV_EN
        rem      <= '0;
        is_div_q <= is_dv;
        dz_q     <= is_dv && b_zero;
        neg_r    <= sgn && Read_A[WIDTH-1];
`endif
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
`ifdef MULDIV_DIV_EN
        rem <= rem_step;
`endif
      end else if (state == FIX) begin
        HI <= hi_fix;
        LO <= lo_fix;
      end else if (start && idle && is_mv_hi) begin
        HI <= Read_A;
      end else if (start && idle && is_mv_lo) begin
        LO <= Read_A;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl; divide scenarios follow MULDIV_DIV_EN.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] Read_A, Read_B;
  logic         busy, done, stall, illegal;
  logic [W-1:0] HI, LO, mf_data;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct   (funct),
    .Read_A  (Read_A),
    .Read_B  (Read_B),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .HI      (HI),
    .LO      (LO),
    .mf_data (mf_data),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Issues one op and returns how many falling edges passed before done (bounded at 100).
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int n);
    @(negedge clk);
    start = 1'b1; funct = f; Read_A = a; Read_B = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end while (!done && n < 100);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; funct = '0; Read_A = '0; Read_B = '0;
    repeat (2) @(negedge clk);
    checks++; if (HI !== '0)      begin errors++; $display("FAIL reset_hi got %h want 0", HI); end
    checks++; if (LO !== '0)      begin errors++; $display("FAIL reset_lo got %h want 0", LO); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    rst = 1'b0;
  endtask

  task automatic test_multu_max();
    int n;
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checks++; if (n !== 34) begin errors++; $display("FAIL multu_latency got %0d want 34", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
    checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", HI); end
    checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", LO); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult_signed();
    int n;
    run_op(FUNCT_MULT, -32'sd7, 32'd3, n);
    checks++; if (n !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", n); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", LO); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int n;
    run_op(FUNCT_DIV, -32'sd7, 32'd2, n);
    checks++; if (n !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", n); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", HI); end
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (LO !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", LO); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", HI); end
    run_op(FUNCT_DIVU, 32'd100, 32'd7, n);
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", HI); end
    run_op(FUNCT_DIV, 32'd5, 32'd0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL divz_latency got %0d want 2", n); end
    checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", LO); end
    checks++; if (HI !== 32'd5) begin errors++; $display("FAIL divz_hi got %h want 00000005", HI); end
  endtask
`else
  task automatic test_div();
    @(negedge clk);
    start = 1'b1; funct = FUNCT_DIV; Read_A = -32'sd7; Read_B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL div_off_illegal got %b want 1", illegal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_off_busy got %b want 0", busy); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_off_hi got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL div_off_lo got %h want ffffffeb", LO); end
    @(negedge clk);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL div_off_pulse got %b want 0", illegal); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_off_done got %b want 0", done); end
  endtask
`endif

  task automatic test_reset_mid_calc();
    int n;
    @(negedge clk);
    start = 1'b1; funct = FUNCT_MULTU; Read_A = 32'hFFFF; Read_B = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midcalc_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (HI !== '0) begin errors++; $display("FAIL midcalc_hi got %h want 0", HI); end
    checks++; if (LO !== '0) begin errors++; $display("FAIL midcalc_lo got %h want 0", LO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midcalc_rst_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    run_op(FUNCT_MULTU, 32'd3, 32'd5, n);
    checks++; if (n !== 34) begin errors++; $display("FAIL after_rst_latency got %0d want 34", n); end
    checks++; if (LO !== 32'd15) begin errors++; $display("FAIL after_rst_lo got %h want 0000000f", LO); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; funct = FUNCT_MULT; Read_A = 32'd6; Read_B = 32'd7;
    @(negedge clk);
    funct = FUNCT_MFLO;
    for (int i = 0; i < 33; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d] got %b want 1", i, stall); end
      @(negedge clk);
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_release got %b want 0", stall); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    checks++; if (mf_data !== 32'd42) begin errors++; $display("FAIL b2b_mflo got %h want 0000002a", mf_data); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL b2b_hi got %h want 0", HI); end
    funct = FUNCT_MTHI; Read_A = 32'h1234;
    @(negedge clk);
    checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h want 00001234", HI); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b want 0", done); end
    funct = FUNCT_MFHI;
    #1;
    checks++; if (mf_data !== 32'h1234) begin errors++; $display("FAIL mfhi_data got %h want 00001234", mf_data); end
    start = 1'b0;
  endtask

  task automatic test_illegal_and_mtlo();
    @(negedge clk);
    start = 1'b1; funct = 6'b000000; Read_A = 32'h5555; Read_B = 32'd1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse got %b want 1", illegal); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b want 0", busy); end
    @(negedge clk);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b want 0", illegal); end
    start = 1'b1; funct = FUNCT_MTLO; Read_A = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    checks++; if (LO !== 32'hABCD) begin errors++; $display("FAIL mtlo_lo got %h want 0000abcd", LO); end
    checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mtlo_hi got %h want 00001234", HI); end
    funct = FUNCT_MFLO;
    #1;
    checks++; if (mf_data !== 32'hABCD) begin errors++; $display("FAIL mflo_data got %h want 0000abcd", mf_data); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_reset_mid_calc();
    test_back_to_back();
    test_illegal_and_mtlo();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
